transpose_row_feeder: RTL and testbench
=======================================

# transpose_row_feeder

Upstream sequencer for the matrix-transpose butterfly network. It accepts one matrix row per handshake and drives the first butterfly stage with registered row data and `in_val`. It generates the per-stage switch controls from the row index, each delayed so it arrives at its stage together with the data. It also counts rows returning from the last stage and pulses `matrix_done` when a full NUM_INPUTS×NUM_INPUTS matrix has left the network.

## Interface
Parameters:
- DATA_WIDTH, 64, element width in bits.
- NUM_INPUTS, 16, elements per row and rows per matrix; power of two, ≥ 2.
- NUM_SWITCHES (localparam), NUM_INPUTS/2, switches per stage.
- NUM_STAGES (localparam), $clog2(NUM_INPUTS), butterfly stages downstream.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; one clock, synchronous, active-high.
- s_val  in  1  upstream row valid.
- s_rdy  out  1  feeder can accept a row.
- s_elements  in  DATA_WIDTH × [0:NUM_INPUTS-1]  row elements.
- net_val  out  1  drives stage-0 `in_val`.
- net_elements  out  DATA_WIDTH × [0:NUM_INPUTS-1]  drives stage-0 `input_elements`.
- net_ctrls  out  NUM_STAGES*NUM_SWITCHES  stage s ctrls at bits [s*NUM_SWITCHES +: NUM_SWITCHES].
- net_out_val  in  1  `out_val` of the last stage.
- row_idx  out  $clog2(NUM_INPUTS)  index of the next row to be accepted.
- matrix_done  out  1  one-cycle pulse when the last row of a matrix exits the network.

## Operation
- Accept: a transfer happens when s_val && s_rdy. On each transfer, row_idx increments and wraps from NUM_INPUTS-1 to 0.
- Data path: net_elements is loaded from s_elements on each transfer and holds otherwise. net_val = registered transfer.
- Control generation: the base ctrl for a row with index r at stage s is bit s of r, replicated across all NUM_SWITCHES bits of that stage.
  - The feeder keeps a shift pipeline of row indices, NUM_STAGES deep.
  - Stage s uses the index of the row currently held in stage s's input register, i.e. the row accepted s cycles before the row now on net_elements.
  - When that slot holds a bubble (no valid row), the stage's ctrls are 0.
- FSM:
  - IDLE: row_idx=0, s_rdy=1. Go to LOAD on the first transfer.
  - LOAD: s_rdy=1. On the transfer with row_idx==NUM_INPUTS-1, go to DRAIN if TRANSPOSE_DRAIN_EN is defined, else to IDLE.
  - DRAIN: s_rdy=0. Go to IDLE in the cycle matrix_done is asserted.
- Output tracking: out_cnt counts net_out_val pulses modulo NUM_INPUTS. When the pulse for count NUM_INPUTS-1 arrives, the next cycle asserts matrix_done and out_cnt wraps to 0.
- No backpressure from the network: once accepted, a row always advances.

## Timing
- Transfer at cycle t: net_val=1 and net_elements valid at t+1. Stage-s ctrls for that row are valid at t+1+s.
- Network latency is NUM_STAGES cycles. net_out_val for the row is expected at t+1+NUM_STAGES; matrix_done rises one cycle after the final net_out_val.
- Full throughput is one row per cycle. s_rdy is a registered function of state only; it never depends combinationally on s_val.
- Back-to-back matrices (macro off): row 0 of the next matrix may be accepted in the cycle after row NUM_INPUTS-1. Ctrl stages stay correct because the index travels with the row.
- Reset values: s_rdy=1, net_val=0, net_ctrls=0, row_idx=0, matrix_done=0, out_cnt=0, FSM=IDLE, index pipeline all bubbles. net_elements is don't-care.
- Reset mid-matrix: all of the above restored next cycle. Rows already in the network are discarded; any net_out_val seen during or after reset for those rows is ignored by out_cnt only while rst=1.
- A net_out_val in the same cycle as a transfer: both counters update independently.

## Configuration
- TRANSPOSE_DRAIN_EN defined: after the last row of a matrix, the FSM enters DRAIN and holds s_rdy=0 until matrix_done. Matrices never overlap in the network.
- TRANSPOSE_DRAIN_EN not defined: DRAIN is unreachable and s_rdy is always 1 outside reset. Matrices stream back-to-back.

## Test plan
- Reset check: rst=1 for 2 cycles, then rst=0 with s_val=0 -> s_rdy=1, net_val=0, net_ctrls=0, row_idx=0, matrix_done=0.
- Single matrix, NUM_INPUTS=16, rows driven continuously from cycle 10 -> net_val high for cycles 11–26. For the row with r=5, stage 0 ctrls all 1 at its first cycle; stage 1 ctrls all 0 one cycle later; stage 2 ctrls all 1 two cycles later.
- Feed net_out_val as net_val delayed by 4 cycles (NUM_STAGES=4) -> matrix_done pulses exactly once, one cycle after the 16th net_out_val.
- Macro on, s_val held high across two matrices -> s_rdy=0 from the cycle after row 15 until matrix_done. Row 0 of the second matrix is accepted the cycle after matrix_done.
- Macro off, same stimulus -> 32 consecutive transfers with no gap, and each row's ctrls match its own index at every stage.
- s_val toggled 1,0,1,0 -> bubbles appear on net_val, and a stage's ctrls are 0 whenever its slot holds a bubble. Assert rst at row 7 -> row_idx=0 and FSM=IDLE next cycle.

Source files
------------

// File: rtl/transpose_row_feeder_if.sv
// Row handshake between the upstream sequencer and transpose_row_feeder.
// One row of NUM_INPUTS elements moves per s_val && s_rdy.
interface transpose_row_feeder_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_INPUTS = 16
);

  logic                                  s_val;
  logic                                  s_rdy;
  logic [0:NUM_INPUTS-1][DATA_WIDTH-1:0] s_elements;

  modport master (
    output s_val,
    output s_elements,
    input  s_rdy
  );

  modport slave (
    input  s_val,
    input  s_elements,
    output s_rdy
  );

endinterface

// File: rtl/transpose_row_feeder.sv
// Row feeder and switch-control sequencer for the transpose butterfly network.
// Define TRANSPOSE_DRAIN_EN to stall intake until each matrix has left the net.
module transpose_row_feeder #(
  parameter  int DATA_WIDTH   = 64,
  parameter  int NUM_INPUTS   = 16,
  localparam int NUM_SWITCHES = NUM_INPUTS / 2,
  localparam int NUM_STAGES   = $clog2(NUM_INPUTS)
) (
  input  logic clk,
  input  logic rst,

  transpose_row_feeder_if.slave s,

  output logic                                  net_val,
  output logic [0:NUM_INPUTS-1][DATA_WIDTH-1:0] net_elements,
  output logic [NUM_STAGES*NUM_SWITCHES-1:0]    net_ctrls,
  input  logic                                  net_out_val,

  output logic [NUM_STAGES-1:0] row_idx,
  output logic                  matrix_done
);

  localparam int            IW   = NUM_STAGES;
  localparam logic [IW-1:0] LAST = IW'(NUM_INPUTS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          s_rdy_q, s_rdy_d;
  logic          xfer;
  logic [IW-1:0] row_idx_q, row_idx_d;
  logic [IW-1:0] out_cnt_q, out_cnt_d;
  logic          matrix_done_q, matrix_done_d;
  logic          net_val_q;

  logic [0:NUM_INPUTS-1][DATA_WIDTH-1:0] elem_q;

  logic [NUM_STAGES-1:0]         slot_v_q, slot_v_d;
  logic [NUM_STAGES-1:0][IW-1:0] slot_idx_q, slot_idx_d;

  assign xfer = s.s_val && s_rdy_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) state_d = LOAD;
      end
      LOAD: begin
        if (xfer && row_idx_q == LAST) begin
`ifdef TRANSPOSE_DRAIN_EN
          state_d = DRAIN;
`else
          state_d = IDLE;
`endif
        end
      end
      DRAIN: begin
        if (matrix_done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is registered from the next state so it never sees s_val.
  assign s_rdy_d   = (state_d != DRAIN);
  assign row_idx_d = xfer ? row_idx_q + IW'(1) : row_idx_q;

  assign matrix_done_d = net_out_val && (out_cnt_q == LAST);
  assign out_cnt_d     = net_out_val ? out_cnt_q + IW'(1) : out_cnt_q;

  // Slot k tracks the row sitting at the input register of stage k.
  always_comb begin
    slot_v_d      = '0;
    slot_idx_d    = '0;
    slot_v_d[0]   = xfer;
    slot_idx_d[0] = row_idx_q;
    for (int k = 1; k < NUM_STAGES; k++) begin
      slot_v_d[k]   = slot_v_q[k-1];
      slot_idx_d[k] = slot_idx_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      s_rdy_q       <= 1'b1;
      row_idx_q     <= '0;
      out_cnt_q     <= '0;
      matrix_done_q <= 1'b0;
      net_val_q     <= 1'b0;
      slot_v_q      <= '0;
      slot_idx_q    <= '0;
    end else begin
      state_q       <= state_d;
      s_rdy_q       <= s_rdy_d;
      row_idx_q     <= row_idx_d;
      out_cnt_q     <= out_cnt_d;
      matrix_done_q <= matrix_done_d;
      net_val_q     <= xfer;
      slot_v_q      <= slot_v_d;
      slot_idx_q    <= slot_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) elem_q <= s.s_elements;
  end

  always_comb begin
    net_ctrls = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      net_ctrls[k*NUM_SWITCHES +: NUM_SWITCHES] =
        {NUM_SWITCHES{slot_v_q[k] &
          (|(slot_idx_q[k] & (IW'(1) << k)))}};
    end
  end

  assign s.s_rdy       = s_rdy_q;
  assign net_val       = net_val_q;
  assign net_elements  = elem_q;
  assign row_idx       = row_idx_q;
  assign matrix_done   = matrix_done_q;

endmodule

// File: tb/tb_transpose_row_feeder.sv
// Randomized bench for transpose_row_feeder against a cycle-history model.
// Honours TRANSPOSE_DRAIN_EN the same way the design does.
module tb_transpose_row_feeder;

  localparam int DW  = 64;
  localparam int N   = 16;
  localparam int NS  = $clog2(N);
  localparam int NSW = N / 2;
  localparam int IW  = NS;
  localparam int HR  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  transpose_row_feeder_if #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) sif ();

  logic                         net_val;
  logic [0:N-1][DW-1:0]         net_elements;
  logic [NS*NSW-1:0]            net_ctrls;
  logic                         net_out_val;
  logic [IW-1:0]                row_idx;
  logic                         matrix_done;

  transpose_row_feeder #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .s            (sif),
    .net_val      (net_val),
    .net_elements (net_elements),
    .net_ctrls    (net_ctrls),
    .net_out_val  (net_out_val),
    .row_idx      (row_idx),
    .matrix_done  (matrix_done)
  );

  int checks = 0;
  int errors = 0;

  // history of accepted rows, one entry per clock edge
  bit            hv [HR];
  logic [IW-1:0] hi [HR];
  int            n        = 0;
  int            last_rst = -1;
  int            m_idx    = 0;
  int            m_cnt    = 0;
  bit            m_md     = 0;
  bit            m_rdy    = 1;
  bit            m_drain  = 0;
  bit            dl [0:NS];
  bit            nov      = 0;
  logic [0:N-1][DW-1:0] m_data;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, n);
    end
  endtask

  task automatic compare();
    logic [NS*NSW-1:0] ec;
    int m;
    int k;
    chk("s_rdy", 64'(sif.s_rdy), 64'(m_rdy));
    chk("net_val", 64'(net_val), 64'(hv[n % HR]));
    chk("row_idx", 64'(row_idx), 64'(m_idx));
    chk("matrix_done", 64'(matrix_done), 64'(m_md));
    ec = '0;
    for (int s = 0; s < NS; s++) begin
      m = n - s;
      if (m > last_rst && m >= 0 && hv[m % HR] && hi[m % HR][s])
        ec[s*NSW +: NSW] = {NSW{1'b1}};
    end
    chk("net_ctrls", 64'(net_ctrls), 64'(ec));
    if (hv[n % HR]) begin
      k = 0;
      for (int e = N - 1; e >= 0; e--)
        if (net_elements[e] !== m_data[e]) k = e;
      chk("net_elements", net_elements[k], m_data[k]);
    end
  endtask

  task automatic step(bit v, bit r);
    bit xfer;
    bit md_prev;
    sif.s_val   = v;
    rst         = r;
    net_out_val = nov;
    for (int e = 0; e < N; e++)
      sif.s_elements[e] = {$urandom(), $urandom()};
    @(posedge clk);
    xfer    = v && m_rdy && !r;
    md_prev = m_md;
    hv[n % HR] = xfer;
    hi[n % HR] = IW'(m_idx);
    if (r) begin
      m_cnt    = 0;
      m_md     = 0;
      m_idx    = 0;
      m_drain  = 0;
      last_rst = n;
    end else begin
      m_md = nov && (m_cnt == N - 1);
      if (nov) m_cnt = (m_cnt + 1) % N;
      if (md_prev) m_drain = 0;
      if (xfer) begin
        m_data = sif.s_elements;
`ifdef TRANSPOSE_DRAIN_EN
        if (m_idx == N - 1) m_drain = 1;
`endif
        m_idx = (m_idx + 1) % N;
      end
    end
    m_rdy = !m_drain;
    // ideal network: a row re-appears NS cycles after it was launched
    for (int k = NS; k > 0; k--) dl[k] = dl[k-1];
    dl[0] = xfer;
    if (r) for (int k = 0; k <= NS; k++) dl[k] = 0;
    nov = dl[NS];
    @(negedge clk);
    compare();
    n++;
  endtask

  int vcount;
  int mdcount;
  int mdcyc;
  int lowcnt;
  int guard;

  initial begin
    for (int i = 0; i < HR; i++) begin
      hv[i] = 0;
      hi[i] = '0;
    end
    for (int k = 0; k <= NS; k++) dl[k] = 0;
    sif.s_val   = 1'b0;
    net_out_val = 1'b0;
    rst         = 1'b1;

    step(0, 1);
    step(0, 1);
    step(0, 0);
    chk("rst_s_rdy", 64'(sif.s_rdy), 64'd1);
    chk("rst_net_val", 64'(net_val), 64'd0);
    chk("rst_net_ctrls", 64'(net_ctrls), 64'd0);
    chk("rst_row_idx", 64'(row_idx), 64'd0);
    chk("rst_matrix_done", 64'(matrix_done), 64'd0);

    repeat (6) step(0, 0);

    // one matrix driven continuously
    vcount  = 0;
    mdcount = 0;
    mdcyc   = -1;
    for (int c = 0; c < 30; c++) begin
      step(c < 16, 0);
      vcount += int'(net_val);
      if (matrix_done) begin
        mdcount++;
        mdcyc = c;
      end
      if (c == 5) chk("r5_stage0", 64'(net_ctrls[0 +: NSW]), 64'hFF);
      if (c == 6) chk("r5_stage1", 64'(net_ctrls[NSW +: NSW]), 64'h00);
      if (c == 7) chk("r5_stage2", 64'(net_ctrls[2*NSW +: NSW]), 64'hFF);
    end
    chk("single_val_count", 64'(vcount), 64'd16);
    chk("single_md_count", 64'(mdcount), 64'd1);
    chk("single_md_cycle", 64'(mdcyc), 64'd20);

    // two matrices with s_val held high
    vcount = 0;
    lowcnt = 0;
    for (int c = 0; c < 48; c++) begin
      step(1, 0);
      if (c < 32) vcount += int'(net_val);
      lowcnt += int'(!sif.s_rdy);
    end
`ifdef TRANSPOSE_DRAIN_EN
    chk("drain_rdy_low", 64'(lowcnt), 64'd12);
`else
    chk("b2b_val_count", 64'(vcount), 64'd32);
    chk("b2b_rdy_low", 64'(lowcnt), 64'd0);
`endif

    // random traffic with occasional resets
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 2);

    // bubbles, then reset in the middle of a matrix
    step(0, 1);
    step(0, 0);
    for (int c = 0; c < 4; c++) begin
      step(c % 2 == 0, 0);
      chk("toggle_net_val", 64'(net_val), 64'(c % 2 == 0));
    end
    guard = 0;
    while (m_idx != 7 && guard < 40) begin
      step(1, 0);
      guard++;
    end
    chk("reach_row7", 64'(row_idx), 64'd7);
    step(1, 1);
    chk("rst7_row_idx", 64'(row_idx), 64'd0);
    chk("rst7_s_rdy", 64'(sif.s_rdy), 64'd1);
    chk("rst7_net_val", 64'(net_val), 64'd0);
    chk("rst7_net_ctrls", 64'(net_ctrls), 64'd0);
    repeat (10) step(0, 0);
    chk("post_rst_md", 64'(matrix_done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
